// File: rtl/led_seq.sv
// led_seq: LED register write arbiter with a blink/rotate pattern sequencer.
// Define LED_SEQ_IRQ_EN to build the rotate step counter and wrap interrupt.
module led_seq #(
  parameter int unsigned      CNT_W      = 32,
  parameter logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(50_000_000)
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [1:0]  Addr,
  input  logic [31:0] Wd,
  input  logic        We,
  output logic [31:0] Rd,
  output logic [31:0] Led_Wd,
  output logic        Led_We,
  output logic        Irq
);

  typedef enum logic [1:0] {
    ST_STOP,
    ST_COUNT,
    ST_PUSH
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      data_q, data_d;
  logic [31:0]      pat_q, pat_d;
  logic [31:0]      led_wd_q, led_wd_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             run_q, run_d;
  logic             phase_q, phase_d;
  logic             led_we_q, led_we_d;
  logic             irq_bit;

  logic wr_data, wr_ctrl, wr_per;
  logic go, tick;

`ifdef LED_SEQ_IRQ_EN
  logic [4:0] step_q, step_d;
  logic       irq_q, irq_d;
  assign irq_bit = irq_q;
`else
  assign irq_bit = 1'b0;
`endif

  assign wr_data = We && (Addr == 2'd0);
  assign wr_ctrl = We && (Addr == 2'd1);
  assign wr_per  = We && (Addr == 2'd2);
  assign tick    = (state_q == ST_COUNT) &&
                   (cnt_q == period_q - CNT_W'(1));

  always_comb begin
    data_d   = data_q;
    run_d    = run_q;
    mode_d   = mode_q;
    period_d = period_q;
    pat_d    = pat_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    state_d  = state_q;
    led_we_d = 1'b0;
    led_wd_d = led_wd_q;
`ifdef LED_SEQ_IRQ_EN
    step_d   = step_q;
    irq_d    = irq_q;
`endif
    if (wr_data) data_d = Wd;
    if (wr_ctrl) begin
      run_d  = Wd[2];
      mode_d = Wd[1:0];
    end
    if (wr_per) period_d = CNT_W'(Wd);
    go = run_d && (period_d != '0);

    // Any CPU write pre-empts a tick landing in the same cycle.
    if (wr_data || wr_ctrl) begin
      pat_d    = wr_data ? Wd : data_q;
      cnt_d    = '0;
      phase_d  = 1'b0;
      led_we_d = 1'b1;
      led_wd_d = pat_d;
      state_d  = go ? ST_PUSH : ST_STOP;
`ifdef LED_SEQ_IRQ_EN
      step_d   = 5'd0;
      if (wr_ctrl) irq_d = 1'b0;
`endif
    end else if (wr_per) begin
      cnt_d   = '0;
      state_d = (go && state_q != ST_STOP) ? ST_COUNT : ST_STOP;
    end else begin
      unique case (state_q)
        ST_STOP: begin
          cnt_d = '0;
          if (go) state_d = ST_COUNT;
        end
        ST_COUNT: begin
          if (!go) begin
            cnt_d   = '0;
            state_d = ST_STOP;
          end else if (tick) begin
            cnt_d = '0;
            unique case (mode_q)
              2'd1: begin
                phase_d = ~phase_q;
                pat_d   = phase_q ? data_q : 32'd0;
              end
              2'd2:    pat_d = {pat_q[30:0], pat_q[31]};
              2'd3:    pat_d = {pat_q[0], pat_q[31:1]};
              default: pat_d = pat_q;
            endcase
            if (mode_q != 2'd0) begin
              state_d  = ST_PUSH;
              led_we_d = 1'b1;
              led_wd_d = pat_d;
            end
`ifdef LED_SEQ_IRQ_EN
            if (mode_q[1]) begin
              step_d = step_q + 5'd1;
              if (step_q == 5'd31) irq_d = 1'b1;
            end
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_PUSH: state_d = go ? ST_COUNT : ST_STOP;
        default: state_d = ST_STOP;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q  <= ST_STOP;
      data_q   <= '0;
      run_q    <= 1'b0;
      mode_q   <= 2'd0;
      period_q <= DEF_PERIOD;
      pat_q    <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      led_we_q <= 1'b0;
      led_wd_q <= '0;
`ifdef LED_SEQ_IRQ_EN
      step_q   <= 5'd0;
      irq_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      run_q    <= run_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      pat_q    <= pat_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      led_we_q <= led_we_d;
      led_wd_q <= led_wd_d;
`ifdef LED_SEQ_IRQ_EN
      step_q   <= step_d;
      irq_q    <= irq_d;
`endif
    end
  end

  always_comb begin
    unique case (Addr)
      2'd0:    Rd = data_q;
      2'd1:    Rd = {28'd0, irq_bit, run_q, mode_q};
      2'd2:    Rd = 32'(period_q);
      default: Rd = pat_q;
    endcase
  end

  assign Led_Wd = led_wd_q;
  assign Led_We = led_we_q;
  assign Irq    = irq_bit;

endmodule

// File: tb/tb_led_seq.sv
// Self-checking bench for led_seq: strobe timing and pattern sequences
// are predicted from the register-level rules and compared per strobe.
module tb_led_seq;
  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        We = 1'b0;
  logic [1:0]  Addr = 2'd0;
  logic [31:0] Wd = 32'd0;
  logic [31:0] Rd, Led_Wd;
  logic        Led_We, Irq;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  localparam logic [31:0] DEF = 32'd50_000_000;
`ifdef LED_SEQ_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  typedef struct {
    int          c;
    logic [31:0] v;
    logic        irq;
  } strobe_t;
  strobe_t got[$];

  led_seq dut (
    .Clk(Clk), .Reset_n(Reset_n), .Addr(Addr), .Wd(Wd), .We(We),
    .Rd(Rd), .Led_Wd(Led_Wd), .Led_We(Led_We), .Irq(Irq)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  always @(negedge Clk)
    if (Led_We === 1'b1) got.push_back('{c: cyc, v: Led_Wd, irq: Irq});

  // Strobe k after a run start: k=0 is the pass-through of DATA.
  function automatic logic [31:0] exp_val(input int mode,
                                          input logic [31:0] d,
                                          input int k);
    int s;
    s = k % 32;
    if (k == 0) return d;
    case (mode)
      1:       return ((k % 2) != 0) ? 32'd0 : d;
      2:       return (s == 0) ? d : ((d << s) | (d >> (32 - s)));
      3:       return (s == 0) ? d : ((d >> s) | (d << (32 - s)));
      default: return d;
    endcase
  endfunction

  task automatic step_to(input int t);
    while (cyc < t) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d,
                    input int t, output int wc);
    if (t >= 0) step_to(t);
    Addr = a;
    Wd   = d;
    We   = 1'b1;
    wc   = cyc;
    @(posedge Clk);
    #1;
    We = 1'b0;
  endtask

  task automatic setup(input logic [31:0] d, input int p);
    int w;
    wr(2'd1, 32'd0, -1, w);
    wr(2'd0, d, -1, w);
    wr(2'd2, 32'(p), -1, w);
    step_to(cyc + 1);
    got.delete();
  endtask

  task automatic test_reset;
    logic [31:0] e;
    Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    n_cmp += 3;
    if (Led_We !== 1'b0) begin
      n_bad++; $display("FAIL reset_we: got %b want 0", Led_We);
    end
    if (Led_Wd !== 32'd0) begin
      n_bad++; $display("FAIL reset_wd: got %h want 0", Led_Wd);
    end
    if (Irq !== 1'b0) begin
      n_bad++; $display("FAIL reset_irq: got %b want 0", Irq);
    end
    for (int a = 0; a < 4; a++) begin
      Addr = a[1:0];
      #1;
      e = (a == 2) ? DEF : 32'd0;
      n_cmp++;
      if (Rd !== e) begin
        n_bad++; $display("FAIL reset_rd%0d: got %h want %h", a, Rd, e);
      end
    end
    Reset_n = 1'b1;
    step_to(cyc + 1);
    got.delete();
  endtask

  task automatic test_passthrough;
    logic [31:0] d;
    int w;
    for (int it = 0; it < 3; it++) begin
      d = (it == 0) ? 32'hA5A5_0F0F : $urandom;
      setup(32'h0, 7);
      wr(2'd0, d, -1, w);
      step_to(w + 101);
      n_cmp += 3;
      if (got.size() != 1) begin
        n_bad++; $display("FAIL pass_count: got %0d want 1", got.size());
      end
      if (got.size() < 1 || got[0].c != w + 1) begin
        n_bad++; $display("FAIL pass_cycle: wrote @%0d, strobe missing/late", w);
      end else if (got[0].v !== d) begin
        n_bad++; $display("FAIL pass_val: got %h want %h", got[0].v, d);
      end
      Addr = 2'd3;
      #1;
      if (Rd !== d) begin
        n_bad++; $display("FAIL pass_pat: got %h want %h", Rd, d);
      end
    end
  endtask

  task automatic test_blink;
    logic [31:0] d;
    int p, w, n, e;
    n = 8;
    for (int it = 0; it < 3; it++) begin
      d = (it == 0) ? 32'hFFFF_FFFF : $urandom;
      p = (it == 0) ? 4 : $urandom_range(1, 6);
      setup(d, p);
      wr(2'd1, 32'h5, -1, w);
      step_to(w + 2 + (n - 1) * (p + 1));
      n_cmp++;
      if (got.size() != n) begin
        n_bad++; $display("FAIL blink_count: got %0d want %0d", got.size(), n);
      end
      for (int k = 0; k < n && k < got.size(); k++) begin
        e = w + 1 + k * (p + 1);
        n_cmp++;
        if (got[k].c != e || got[k].v !== exp_val(1, d, k)) begin
          n_bad++;
          $display("FAIL blink_%0d: got %h@%0d want %h@%0d", k,
                   got[k].v, got[k].c, exp_val(1, d, k), e);
        end
      end
    end
  endtask

  task automatic test_rotate;
    logic [31:0] d;
    logic        ei;
    int p, w, n, e, m;
    n = 36;
    for (int it = 0; it < 3; it++) begin
      d = (it == 0) ? 32'h1 : $urandom;
      p = (it == 0) ? 1 : $urandom_range(1, 3);
      m = (it == 0) ? 2 : $urandom_range(2, 3);
      setup(d, p);
      wr(2'd1, 32'(4 + m), -1, w);
      step_to(w + 2 + (n - 1) * (p + 1));
      n_cmp++;
      if (got.size() != n) begin
        n_bad++; $display("FAIL rot_count: got %0d want %0d", got.size(), n);
      end
      for (int k = 0; k < n && k < got.size(); k++) begin
        e  = w + 1 + k * (p + 1);
        ei = IRQ_EN && (k >= 32);
        n_cmp++;
        if (got[k].c != e || got[k].v !== exp_val(m, d, k) ||
            got[k].irq !== ei) begin
          n_bad++;
          $display("FAIL rot_%0d: got %h@%0d irq %b want %h@%0d irq %b", k,
                   got[k].v, got[k].c, got[k].irq, exp_val(m, d, k), e, ei);
        end
      end
      Addr = 2'd1;
      #1;
      n_cmp++;
      if (Rd !== {28'd0, IRQ_EN, 1'b1, 2'(m)}) begin
        n_bad++; $display("FAIL rot_ctrl_rd: got %h want %h", Rd,
                          {28'd0, IRQ_EN, 1'b1, 2'(m)});
      end
      wr(2'd1, 32'd0, -1, w);
      n_cmp++;
      if (Irq !== 1'b0 || Rd !== 32'd0) begin
        n_bad++; $display("FAIL irq_clear: got irq %b rd %h want 0 0", Irq, Rd);
      end
    end
  endtask

  task automatic test_collision;
    logic [31:0] d0, nd;
    logic [31:0] ev[$];
    int          ec[$];
    int p, w, t, wc, e;
    for (int it = 0; it < 2; it++) begin
      d0 = $urandom;
      nd = (it == 0) ? 32'h1234_5678 : $urandom;
      p  = $urandom_range(2, 5);
      setup(d0, p);
      wr(2'd1, 32'h6, -1, w);
      t = w + 3 * (p + 1);
      wr(2'd0, nd, t, wc);
      e = t + 1 + 2 * (p + 1);
      step_to(e + 1);
      ev.delete();
      ec.delete();
      for (int k = 0; k < 3; k++) begin
        ec.push_back(w + 1 + k * (p + 1));
        ev.push_back(exp_val(2, d0, k));
      end
      for (int k = 0; k < 3; k++) begin
        ec.push_back(t + 1 + k * (p + 1));
        ev.push_back(exp_val(2, nd, k));
      end
      n_cmp++;
      if (got.size() != ec.size()) begin
        n_bad++; $display("FAIL coll_count: got %0d want %0d", got.size(), ec.size());
      end
      for (int k = 0; k < ec.size() && k < got.size(); k++) begin
        n_cmp++;
        if (got[k].c != ec[k] || got[k].v !== ev[k]) begin
          n_bad++;
          $display("FAIL coll_%0d: got %h@%0d want %h@%0d", k,
                   got[k].v, got[k].c, ev[k], ec[k]);
        end
      end
    end
  endtask

  task automatic test_period_zero;
    logic [31:0] d;
    int w;
    d = $urandom;
    setup(d, 0);
    wr(2'd1, 32'h6, -1, w);
    step_to(w + 60);
    n_cmp++;
    if (got.size() != 1 || got[0].v !== d) begin
      n_bad++; $display("FAIL p0_strobes: got %0d strobes want 1 of %h", got.size(), d);
    end
    wr(2'd2, 32'd3, -1, w);
    step_to(w + 2);
    n_cmp++;
    if (got.size() != 1) begin
      n_bad++; $display("FAIL per_wr_nostrobe: got %0d want 1", got.size());
    end
    step_to(w + 40);
    n_cmp++;
    if (got.size() < 2) begin
      n_bad++; $display("FAIL per_resume: got %0d strobes want >1", got.size());
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d, e;
    int p, w, t;
    d = $urandom;
    p = $urandom_range(1, 4);
    setup(d, p);
    wr(2'd1, 32'h6, -1, w);
    t = w + 2 * (p + 1);
    step_to(t);
    Reset_n = 1'b0;
    @(posedge Clk);
    #1;
    n_cmp++;
    if (Led_We !== 1'b0 || Led_Wd !== 32'd0 || Irq !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_out: got we %b wd %h irq %b want 0 0 0",
                        Led_We, Led_Wd, Irq);
    end
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      Addr = a[1:0];
      #1;
      e = (a == 2) ? DEF : 32'd0;
      n_cmp++;
      if (Rd !== e) begin
        n_bad++; $display("FAIL rst_mid_rd%0d: got %h want %h", a, Rd, e);
      end
    end
    step_to(cyc + 40);
    n_cmp++;
    if (got.size() != 2) begin
      n_bad++; $display("FAIL rst_mid_strobes: got %0d want 2", got.size());
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_blink();
    test_rotate();
    test_collision();
    test_period_zero();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
